// File: rtl/c7552.sv
// c7552: registered 32-bit add/subtract with magnitude compare, parity and a
// 69-bit XOR side channel, presented in the c7552 benchmark port footprint.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   N1 .. N241_I      207 scalar inputs, IN[206:0] with N1 as MSB
//                       A = IN[206:175], B = IN[174:143], cin = IN[142],
//                       sub = IN[141], hold = IN[140], pinv = IN[139],
//                       X = IN[138:70], Y = IN[69:1], IN[0] = N241_I
//   N387 .. N241_O    108 scalar registered outputs, OUT[107:0] with N387 as MSB
//                       S = OUT[107:76], cout, gt, eq, lt, pa, pb = OUT[75:70],
//                       M = OUT[69:1], OUT[0] = N241_I feed-through
module c7552 (
   input  logic clk,
   input  logic rst_n,
   input  logic N1, N5, N9, N12, N15, N18, N23, N26, N29, N32, N35, N38, N41, N44, N47, N50,
   input  logic N53, N54, N55, N56, N57, N58, N59, N60, N61, N62, N63, N64, N65, N66, N69, N70,
   input  logic N73, N74, N75, N76, N77, N78, N79, N80, N81, N82, N83, N84, N85, N86, N87, N88,
   input  logic N89, N94, N97, N100, N103, N106, N109, N110, N111, N112, N113, N114, N115,
   input  logic N118, N121, N124, N127, N130, N133, N134, N135, N138, N141, N144, N147, N150,
   input  logic N151, N152, N153, N154, N155, N156, N157, N158, N159, N160, N161, N162,
   input  logic N163, N164, N165, N166, N167, N168, N169, N170, N171, N172, N173, N174,
   input  logic N175, N176, N177, N178, N179, N180, N181, N182, N183, N184, N185, N186,
   input  logic N187, N188, N189, N190, N191, N192, N193, N194, N195, N196, N197, N198,
   input  logic N199, N200, N201, N202, N203, N204, N205, N206, N207, N208, N209, N210,
   input  logic N211, N212, N213, N214, N215, N216, N217, N218, N219, N220, N221, N222,
   input  logic N223, N224, N225, N226, N227, N228, N229, N230, N231, N232, N233, N234,
   input  logic N235, N236, N237, N238, N239, N240, N242, N245, N248, N251, N254, N257,
   input  logic N260, N263, N267, N271, N274, N277, N280, N283, N286, N289, N293, N296,
   input  logic N299, N303, N307, N310, N313, N316, N319, N322, N325, N328, N331, N334,
   input  logic N337, N340, N343, N346, N349, N352, N355, N358, N361, N364, N367, N382,
   input  logic N241_I,
   output logic N387, N388, N478, N482, N484, N486, N489, N492, N501, N505, N507, N509,
   output logic N511, N513, N515, N517, N519, N535, N537, N539, N541, N543, N545, N547,
   output logic N549, N551, N553, N556, N559, N561, N563, N565, N567, N569, N571, N573,
   output logic N582, N643, N707, N813, N881, N882, N883, N884, N885, N889, N945,
   output logic N1110, N1111, N1112, N1113, N1114, N1489, N1490, N1781, N10025,
   output logic N10101, N10102, N10103, N10104, N10109, N10110, N10111, N10112,
   output logic N10350, N10351, N10352, N10353, N10574, N10575, N10576, N10628,
   output logic N10632, N10641, N10704, N10706, N10711, N10712, N10713, N10714,
   output logic N10715, N10716, N10717, N10718, N10729, N10759, N10760, N10761,
   output logic N10762, N10763, N10827, N10837, N10838, N10839, N10840, N10868,
   output logic N10869, N10870, N10871, N10905, N10906, N10907, N10908, N11333,
   output logic N11334, N11340, N11342, N241_O
);

   logic [206:0] in_vec;
   logic [107:0] out_d;
   logic [107:0] out_q;

   assign in_vec = {
      N1, N5, N9, N12, N15, N18, N23, N26, N29, N32, N35, N38, N41, N44, N47, N50,
      N53, N54, N55, N56, N57, N58, N59, N60, N61, N62, N63, N64, N65, N66, N69, N70,
      N73, N74, N75, N76, N77, N78, N79, N80, N81, N82, N83, N84, N85, N86, N87, N88,
      N89, N94, N97, N100, N103, N106, N109, N110, N111, N112, N113, N114, N115,
      N118, N121, N124, N127, N130, N133, N134, N135, N138, N141, N144, N147, N150,
      N151, N152, N153, N154, N155, N156, N157, N158, N159, N160, N161, N162,
      N163, N164, N165, N166, N167, N168, N169, N170, N171, N172, N173, N174,
      N175, N176, N177, N178, N179, N180, N181, N182, N183, N184, N185, N186,
      N187, N188, N189, N190, N191, N192, N193, N194, N195, N196, N197, N198,
      N199, N200, N201, N202, N203, N204, N205, N206, N207, N208, N209, N210,
      N211, N212, N213, N214, N215, N216, N217, N218, N219, N220, N221, N222,
      N223, N224, N225, N226, N227, N228, N229, N230, N231, N232, N233, N234,
      N235, N236, N237, N238, N239, N240, N242, N245, N248, N251, N254, N257,
      N260, N263, N267, N271, N274, N277, N280, N283, N286, N289, N293, N296,
      N299, N303, N307, N310, N313, N316, N319, N322, N325, N328, N331, N334,
      N337, N340, N343, N346, N349, N352, N355, N358, N361, N364, N367, N382,
      N241_I};

   assign {
      N387, N388, N478, N482, N484, N486, N489, N492, N501, N505, N507, N509,
      N511, N513, N515, N517, N519, N535, N537, N539, N541, N543, N545, N547,
      N549, N551, N553, N556, N559, N561, N563, N565, N567, N569, N571, N573,
      N582, N643, N707, N813, N881, N882, N883, N884, N885, N889, N945,
      N1110, N1111, N1112, N1113, N1114, N1489, N1490, N1781, N10025,
      N10101, N10102, N10103, N10104, N10109, N10110, N10111, N10112,
      N10350, N10351, N10352, N10353, N10574, N10575, N10576, N10628,
      N10632, N10641, N10704, N10706, N10711, N10712, N10713, N10714,
      N10715, N10716, N10717, N10718, N10729, N10759, N10760, N10761,
      N10762, N10763, N10827, N10837, N10838, N10839, N10840, N10868,
      N10869, N10870, N10871, N10905, N10906, N10907, N10908, N11333,
      N11334, N11340, N11342, N241_O} = out_q;

   logic [31:0] op_a, op_b, op_b_sel;
   logic        cin, sub, hold, pinv;
   logic [68:0] x, y;
   logic [32:0] sum;

   assign op_a = in_vec[206:175];
   assign op_b = in_vec[174:143];
   assign cin  = in_vec[142];
   assign sub  = in_vec[141];
   assign hold = in_vec[140];
   assign pinv = in_vec[139];
   assign x    = in_vec[138:70];
   assign y    = in_vec[69:1];

   // Subtract is A + ~B + cin; callers set cin=1 for a true two's-complement difference.
   assign op_b_sel = sub ? ~op_b : op_b;
   assign sum      = {1'b0, op_a} + {1'b0, op_b_sel} + {32'd0, cin};

   always_comb begin
      out_d         = '0;
      out_d[107:76] = sum[31:0];
      out_d[75]     = sum[32];
      // Compare uses the raw operands, not the possibly inverted B.
      out_d[74]     = op_a > op_b;
      out_d[73]     = op_a == op_b;
      out_d[72]     = op_a < op_b;
      out_d[71]     = ^op_a ^ pinv;
      out_d[70]     = ^op_b ^ pinv;
      out_d[69:1]   = x ^ y;
      out_d[0]      = in_vec[0];
   end

   // hold freezes every output flop, including the N241 feed-through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else if (!hold) begin
         out_q <= out_d;
      end
   end

endmodule

// File: tb/tb_c7552.sv
module tb_c7552;

   logic         clk;
   logic         rst_n;
   logic [206:0] in_v;
   wire  [107:0] out_v;
   logic [107:0] exp_q;
   int           n_checks;
   int           n_fail;

   wire N1, N5, N9, N12, N15, N18, N23, N26, N29, N32, N35, N38, N41, N44, N47, N50,
        N53, N54, N55, N56, N57, N58, N59, N60, N61, N62, N63, N64, N65, N66, N69, N70,
        N73, N74, N75, N76, N77, N78, N79, N80, N81, N82, N83, N84, N85, N86, N87, N88,
        N89, N94, N97, N100, N103, N106, N109, N110, N111, N112, N113, N114, N115,
        N118, N121, N124, N127, N130, N133, N134, N135, N138, N141, N144, N147, N150,
        N151, N152, N153, N154, N155, N156, N157, N158, N159, N160, N161, N162,
        N163, N164, N165, N166, N167, N168, N169, N170, N171, N172, N173, N174,
        N175, N176, N177, N178, N179, N180, N181, N182, N183, N184, N185, N186,
        N187, N188, N189, N190, N191, N192, N193, N194, N195, N196, N197, N198,
        N199, N200, N201, N202, N203, N204, N205, N206, N207, N208, N209, N210,
        N211, N212, N213, N214, N215, N216, N217, N218, N219, N220, N221, N222,
        N223, N224, N225, N226, N227, N228, N229, N230, N231, N232, N233, N234,
        N235, N236, N237, N238, N239, N240, N242, N245, N248, N251, N254, N257,
        N260, N263, N267, N271, N274, N277, N280, N283, N286, N289, N293, N296,
        N299, N303, N307, N310, N313, N316, N319, N322, N325, N328, N331, N334,
        N337, N340, N343, N346, N349, N352, N355, N358, N361, N364, N367, N382,
        N241_I;

   wire N387, N388, N478, N482, N484, N486, N489, N492, N501, N505, N507, N509,
        N511, N513, N515, N517, N519, N535, N537, N539, N541, N543, N545, N547,
        N549, N551, N553, N556, N559, N561, N563, N565, N567, N569, N571, N573,
        N582, N643, N707, N813, N881, N882, N883, N884, N885, N889, N945,
        N1110, N1111, N1112, N1113, N1114, N1489, N1490, N1781, N10025,
        N10101, N10102, N10103, N10104, N10109, N10110, N10111, N10112,
        N10350, N10351, N10352, N10353, N10574, N10575, N10576, N10628,
        N10632, N10641, N10704, N10706, N10711, N10712, N10713, N10714,
        N10715, N10716, N10717, N10718, N10729, N10759, N10760, N10761,
        N10762, N10763, N10827, N10837, N10838, N10839, N10840, N10868,
        N10869, N10870, N10871, N10905, N10906, N10907, N10908, N11333,
        N11334, N11340, N11342, N241_O;

   assign {
      N1, N5, N9, N12, N15, N18, N23, N26, N29, N32, N35, N38, N41, N44, N47, N50,
      N53, N54, N55, N56, N57, N58, N59, N60, N61, N62, N63, N64, N65, N66, N69, N70,
      N73, N74, N75, N76, N77, N78, N79, N80, N81, N82, N83, N84, N85, N86, N87, N88,
      N89, N94, N97, N100, N103, N106, N109, N110, N111, N112, N113, N114, N115,
      N118, N121, N124, N127, N130, N133, N134, N135, N138, N141, N144, N147, N150,
      N151, N152, N153, N154, N155, N156, N157, N158, N159, N160, N161, N162,
      N163, N164, N165, N166, N167, N168, N169, N170, N171, N172, N173, N174,
      N175, N176, N177, N178, N179, N180, N181, N182, N183, N184, N185, N186,
      N187, N188, N189, N190, N191, N192, N193, N194, N195, N196, N197, N198,
      N199, N200, N201, N202, N203, N204, N205, N206, N207, N208, N209, N210,
      N211, N212, N213, N214, N215, N216, N217, N218, N219, N220, N221, N222,
      N223, N224, N225, N226, N227, N228, N229, N230, N231, N232, N233, N234,
      N235, N236, N237, N238, N239, N240, N242, N245, N248, N251, N254, N257,
      N260, N263, N267, N271, N274, N277, N280, N283, N286, N289, N293, N296,
      N299, N303, N307, N310, N313, N316, N319, N322, N325, N328, N331, N334,
      N337, N340, N343, N346, N349, N352, N355, N358, N361, N364, N367, N382,
      N241_I} = in_v;

   assign out_v = {
      N387, N388, N478, N482, N484, N486, N489, N492, N501, N505, N507, N509,
      N511, N513, N515, N517, N519, N535, N537, N539, N541, N543, N545, N547,
      N549, N551, N553, N556, N559, N561, N563, N565, N567, N569, N571, N573,
      N582, N643, N707, N813, N881, N882, N883, N884, N885, N889, N945,
      N1110, N1111, N1112, N1113, N1114, N1489, N1490, N1781, N10025,
      N10101, N10102, N10103, N10104, N10109, N10110, N10111, N10112,
      N10350, N10351, N10352, N10353, N10574, N10575, N10576, N10628,
      N10632, N10641, N10704, N10706, N10711, N10712, N10713, N10714,
      N10715, N10716, N10717, N10718, N10729, N10759, N10760, N10761,
      N10762, N10763, N10827, N10837, N10838, N10839, N10840, N10868,
      N10869, N10870, N10871, N10905, N10906, N10907, N10908, N11333,
      N11334, N11340, N11342, N241_O};

   c7552 dut (
      .clk(clk), .rst_n(rst_n),
      .N1(N1), .N5(N5), .N9(N9), .N12(N12), .N15(N15), .N18(N18), .N23(N23), .N26(N26),
      .N29(N29), .N32(N32), .N35(N35), .N38(N38), .N41(N41), .N44(N44), .N47(N47),
      .N50(N50), .N53(N53), .N54(N54), .N55(N55), .N56(N56), .N57(N57), .N58(N58),
      .N59(N59), .N60(N60), .N61(N61), .N62(N62), .N63(N63), .N64(N64), .N65(N65),
      .N66(N66), .N69(N69), .N70(N70), .N73(N73), .N74(N74), .N75(N75), .N76(N76),
      .N77(N77), .N78(N78), .N79(N79), .N80(N80), .N81(N81), .N82(N82), .N83(N83),
      .N84(N84), .N85(N85), .N86(N86), .N87(N87), .N88(N88), .N89(N89), .N94(N94),
      .N97(N97), .N100(N100), .N103(N103), .N106(N106), .N109(N109), .N110(N110),
      .N111(N111), .N112(N112), .N113(N113), .N114(N114), .N115(N115), .N118(N118),
      .N121(N121), .N124(N124), .N127(N127), .N130(N130), .N133(N133), .N134(N134),
      .N135(N135), .N138(N138), .N141(N141), .N144(N144), .N147(N147), .N150(N150),
      .N151(N151), .N152(N152), .N153(N153), .N154(N154), .N155(N155), .N156(N156),
      .N157(N157), .N158(N158), .N159(N159), .N160(N160), .N161(N161), .N162(N162),
      .N163(N163), .N164(N164), .N165(N165), .N166(N166), .N167(N167), .N168(N168),
      .N169(N169), .N170(N170), .N171(N171), .N172(N172), .N173(N173), .N174(N174),
      .N175(N175), .N176(N176), .N177(N177), .N178(N178), .N179(N179), .N180(N180),
      .N181(N181), .N182(N182), .N183(N183), .N184(N184), .N185(N185), .N186(N186),
      .N187(N187), .N188(N188), .N189(N189), .N190(N190), .N191(N191), .N192(N192),
      .N193(N193), .N194(N194), .N195(N195), .N196(N196), .N197(N197), .N198(N198),
      .N199(N199), .N200(N200), .N201(N201), .N202(N202), .N203(N203), .N204(N204),
      .N205(N205), .N206(N206), .N207(N207), .N208(N208), .N209(N209), .N210(N210),
      .N211(N211), .N212(N212), .N213(N213), .N214(N214), .N215(N215), .N216(N216),
      .N217(N217), .N218(N218), .N219(N219), .N220(N220), .N221(N221), .N222(N222),
      .N223(N223), .N224(N224), .N225(N225), .N226(N226), .N227(N227), .N228(N228),
      .N229(N229), .N230(N230), .N231(N231), .N232(N232), .N233(N233), .N234(N234),
      .N235(N235), .N236(N236), .N237(N237), .N238(N238), .N239(N239), .N240(N240),
      .N242(N242), .N245(N245), .N248(N248), .N251(N251), .N254(N254), .N257(N257),
      .N260(N260), .N263(N263), .N267(N267), .N271(N271), .N274(N274), .N277(N277),
      .N280(N280), .N283(N283), .N286(N286), .N289(N289), .N293(N293), .N296(N296),
      .N299(N299), .N303(N303), .N307(N307), .N310(N310), .N313(N313), .N316(N316),
      .N319(N319), .N322(N322), .N325(N325), .N328(N328), .N331(N331), .N334(N334),
      .N337(N337), .N340(N340), .N343(N343), .N346(N346), .N349(N349), .N352(N352),
      .N355(N355), .N358(N358), .N361(N361), .N364(N364), .N367(N367), .N382(N382),
      .N241_I(N241_I),
      .N387(N387), .N388(N388), .N478(N478), .N482(N482), .N484(N484), .N486(N486),
      .N489(N489), .N492(N492), .N501(N501), .N505(N505), .N507(N507), .N509(N509),
      .N511(N511), .N513(N513), .N515(N515), .N517(N517), .N519(N519), .N535(N535),
      .N537(N537), .N539(N539), .N541(N541), .N543(N543), .N545(N545), .N547(N547),
      .N549(N549), .N551(N551), .N553(N553), .N556(N556), .N559(N559), .N561(N561),
      .N563(N563), .N565(N565), .N567(N567), .N569(N569), .N571(N571), .N573(N573),
      .N582(N582), .N643(N643), .N707(N707), .N813(N813), .N881(N881), .N882(N882),
      .N883(N883), .N884(N884), .N885(N885), .N889(N889), .N945(N945),
      .N1110(N1110), .N1111(N1111), .N1112(N1112), .N1113(N1113), .N1114(N1114),
      .N1489(N1489), .N1490(N1490), .N1781(N1781), .N10025(N10025),
      .N10101(N10101), .N10102(N10102), .N10103(N10103), .N10104(N10104),
      .N10109(N10109), .N10110(N10110), .N10111(N10111), .N10112(N10112),
      .N10350(N10350), .N10351(N10351), .N10352(N10352), .N10353(N10353),
      .N10574(N10574), .N10575(N10575), .N10576(N10576), .N10628(N10628),
      .N10632(N10632), .N10641(N10641), .N10704(N10704), .N10706(N10706),
      .N10711(N10711), .N10712(N10712), .N10713(N10713), .N10714(N10714),
      .N10715(N10715), .N10716(N10716), .N10717(N10717), .N10718(N10718),
      .N10729(N10729), .N10759(N10759), .N10760(N10760), .N10761(N10761),
      .N10762(N10762), .N10763(N10763), .N10827(N10827), .N10837(N10837),
      .N10838(N10838), .N10839(N10839), .N10840(N10840), .N10868(N10868),
      .N10869(N10869), .N10870(N10870), .N10871(N10871), .N10905(N10905),
      .N10906(N10906), .N10907(N10907), .N10908(N10908), .N11333(N11333),
      .N11334(N11334), .N11340(N11340), .N11342(N11342), .N241_O(N241_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [107:0] got, input logic [107:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [206:0] mk_vec(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub, input logic hold,
                                           input logic pinv, input logic [68:0] x,
                                           input logic [68:0] y, input logic n241);
      return {a, b, cin, sub, hold, pinv, x, y, n241};
   endfunction

   // Reference built from plain arithmetic on the decoded fields.
   function automatic logic [107:0] ref_out(input logic [206:0] v);
      longint unsigned a, b, bop, s;
      logic [107:0]    r;
      logic            pinv;
      a    = longint'(v[206:175]);
      b    = longint'(v[174:143]);
      pinv = v[139];
      bop  = v[141] ? (64'hFFFF_FFFF - b) : b;
      s    = a + bop + longint'(v[142]);
      r         = '0;
      r[107:76] = s[31:0];
      r[75]     = s[32];
      r[74]     = a > b;
      r[73]     = a == b;
      r[72]     = a < b;
      r[71]     = logic'($countones(v[206:175]) % 2) ^ pinv;
      r[70]     = logic'($countones(v[174:143]) % 2) ^ pinv;
      r[69:1]   = v[138:70] ^ v[69:1];
      r[0]      = v[0];
      return r;
   endfunction

   function automatic logic [206:0] rand_vec();
      logic [223:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      w[140] = ($urandom_range(7) == 0);
      return w[206:0];
   endfunction

   // Called at a negedge: drive, clock, update model, check just after the edge.
   task automatic apply(input string tag, input logic [206:0] v);
      in_v = v;
      @(posedge clk);
      if (rst_n && !v[140]) exp_q = ref_out(v);
      #1;
      check_eq(tag, out_v, exp_q);
      @(negedge clk);
   endtask

   logic [206:0] v1, v2;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_q    = '0;
      rst_n    = 1'b0;
      in_v     = rand_vec();
      #1;
      check_eq("reset_immediate", out_v, 108'd0);
      @(negedge clk);
      @(negedge clk);
      check_eq("reset_held", out_v, 108'd0);
      rst_n = 1'b1;

      // Add wrapping to zero with carry out.
      v1 = mk_vec(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      apply("add_first_load", v1);
      check_eq("add_fields", {72'd0, out_v[107:72]}, {72'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      check_eq("add_parity", {106'd0, out_v[71:70]}, {106'd0, 2'b01});

      v1 = mk_vec(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
      apply("pinv_vec", v1);
      check_eq("pinv_parity", {106'd0, out_v[71:70]}, {106'd0, 2'b10});

      v1 = mk_vec(32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      apply("sub_eq_vec", v1);
      check_eq("sub_eq_fields", {72'd0, out_v[107:72]}, {72'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});

      v1 = mk_vec(32'd3, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      apply("sub_lt_vec", v1);
      check_eq("sub_lt_fields", {72'd0, out_v[107:72]},
               {72'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});

      v1 = mk_vec(32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, {69{1'b1}}, 69'h0_AAAA_AAAA_AAAA_AAAA,
                  1'b1);
      apply("side_vec", v1);
      check_eq("side_m", {39'd0, out_v[69:1]}, {39'd0, 69'h1F_5555_5555_5555_5555});
      check_eq("side_n241", {107'd0, out_v[0]}, {107'd0, 1'b1});

      // Hold: V2 carries hold=1 and a flipped N241 bit, outputs must keep V1.
      v1 = rand_vec();
      v1[140] = 1'b0;
      v1[0]   = 1'b1;
      apply("hold_v1", v1);
      v2 = rand_vec();
      v2[140] = 1'b1;
      v2[0]   = 1'b0;
      in_v = v2;
      @(posedge clk);
      #1;
      check_eq("hold_keeps_v1", out_v, ref_out(v1));
      @(negedge clk);
      v2[140] = 1'b0;
      apply("hold_release_v2", v2);
      check_eq("hold_release_ref", out_v, ref_out(v2));

      // Random stream with occasional asynchronous reset pulses between edges.
      for (int i = 0; i < 10000; i++) begin
         apply("random", rand_vec());
         if ($urandom_range(63) == 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            exp_q = '0;
            check_eq("async_reset", out_v, exp_q);
            #1;
            rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
